// File: rtl/ldst_pkg.sv
// Shared types and defaults for the load/store and stack unit.
package ldst_pkg;

  // Memory operation requested by the core.
  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpStore = 2'b01,
    OpPush  = 2'b10,
    OpPop   = 2'b11
  } op_t;

  // Controller states: one cycle of memory access between accept and response.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_t;

  // Stack grows downward from the top of the 256-byte memory.
  localparam logic [7:0] DefaultSpTop   = 8'd255;
  localparam logic [7:0] DefaultSpFloor = 8'd128;

endpackage

// File: rtl/ldst_if.sv
// Core-side request/response handshake of the load/store unit.
interface ldst_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  // Core side: issues requests and consumes responses.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Unit side: accepts requests and produces responses.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ldst_sp_ctr.sv
// Downward-growing stack pointer with full/empty flags.
module ldst_sp_ctr
  import ldst_pkg::*;
#(
  parameter logic [7:0] SP_TOP   = DefaultSpTop,
  parameter logic [7:0] SP_FLOOR = DefaultSpFloor
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp,
  output logic       full,
  output logic       empty
);

  logic [7:0] sp_q;

  // Pointer register; callers guard inc/dec with empty/full so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= SP_TOP;
    end else if (inc) begin
      sp_q <= sp_q + 8'd1;
    end else if (dec) begin
      sp_q <= sp_q - 8'd1;
    end
  end

  assign sp    = sp_q;
  assign full  = (sp_q == SP_FLOOR - 8'd1);
  assign empty = (sp_q == SP_TOP);

endmodule

// File: rtl/ldst_unit.sv
// Load/store and stack unit in front of an 8x256 combinational-read data memory.
module ldst_unit
  import ldst_pkg::*;
#(
  parameter logic [7:0] SP_TOP   = DefaultSpTop,
  parameter logic [7:0] SP_FLOOR = DefaultSpFloor
) (
  input  logic       clk,
  input  logic       rst_n,
  ldst_if.slave      bus,
  output logic [7:0] sp,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr_en,
  input  logic [7:0] mem_rdata
);

  state_t     state_q, state_d;
  op_t        op_q;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic [7:0] mem_addr_q, mem_wdata_q;
  logic       accept;
  logic       sp_inc, sp_dec, sp_full, sp_empty;

  ldst_sp_ctr #(
    .SP_TOP  (SP_TOP),
    .SP_FLOOR(SP_FLOOR)
  ) u_sp_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sp_inc),
    .dec  (sp_dec),
    .sp   (sp),
    .full (sp_full),
    .empty(sp_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Latch the request at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OpLoad;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
    end else if (accept) begin
      op_q    <= op_t'(bus.req_op);
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Memory port drive and result capture; wr_en is only ever high in ACCESS, so an
  // asynchronous reset forcing IDLE removes it immediately.
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wr_en = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    rdata_d   = 8'd0;
    err_d     = 1'b0;
    if (state_q == StAccess) begin
      case (op_q)
        OpLoad: begin
          mem_addr = addr_q;
          rdata_d  = mem_rdata;
        end
        OpStore: begin
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_wr_en = 1'b1;
        end
        OpPush: begin
          if (sp_full) begin
            err_d = 1'b1;
          end else begin
            mem_addr  = sp;
            mem_wdata = wdata_q;
            mem_wr_en = 1'b1;
            sp_dec    = 1'b1;
          end
        end
        OpPop: begin
          if (sp_empty) begin
            err_d = 1'b1;
          end else begin
            mem_addr = sp + 8'd1;
            rdata_d  = mem_rdata;
            sp_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response and held memory-port registers, updated at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q     <= 8'd0;
      err_q       <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
    end else if (state_q == StAccess) begin
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Self-checking bench for ldst_unit: attached memory, reference model, directed + random ops.
module tb_ldst_unit;

  localparam int StackCap = 128;

  logic       clk;
  logic       rst_n;
  logic [7:0] sp;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en;

  ldst_if bus ();

  ldst_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .sp       (sp),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the unit, plus a log of write pulses.
  logic [7:0] mem [256];
  int         wr_cnt;
  logic [7:0] last_wr_addr, last_wr_data;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end
  end

  // Reference model: memory contents and number of items on the stack.
  logic [7:0] model_mem [256];
  int         depth;

  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, predict its outcome from the model, optionally stall the response.
  task automatic do_op(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                       input int hold);
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_writes;
    logic [7:0] exp_wa;
    logic [7:0] held_rdata;
    logic [7:0] held_sp;
    int         wr0;
    int         n;

    exp_rdata  = 8'd0;
    exp_err    = 1'b0;
    exp_writes = 0;
    exp_wa     = addr;
    case (op)
      2'b00: exp_rdata = model_mem[addr];
      2'b01: begin
        model_mem[addr] = wdata;
        exp_writes      = 1;
      end
      2'b10: begin
        if (depth == StackCap) begin
          exp_err = 1'b1;
        end else begin
          exp_wa            = 8'(255 - depth);
          model_mem[exp_wa] = wdata;
          depth++;
          exp_writes = 1;
        end
      end
      default: begin
        if (depth == 0) begin
          exp_err = 1'b1;
        end else begin
          depth--;
          exp_rdata = model_mem[8'(255 - depth)];
        end
      end
    endcase

    @(negedge clk);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (hold == 0);
    wr0           = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("latency", 32'(n), 32'd1);
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("sp", 32'(sp), 32'(255 - depth));
    check("wr_pulses", 32'(wr_cnt - wr0), 32'(exp_writes));
    if (exp_writes == 1) begin
      check("wr_addr", 32'(last_wr_addr), 32'(exp_wa));
      check("wr_data", 32'(last_wr_data), 32'(wdata));
    end

    if (hold > 0) begin
      held_rdata = bus.rsp_rdata;
      held_sp    = sp;
      for (int i = 0; i < hold; i++) begin
        // A competing request must be ignored while the response is pending.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
        @(posedge clk);
        #1;
        check("hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold_rdata", 32'(bus.rsp_rdata), 32'(held_rdata));
        check("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      check("hold_no_write", 32'(wr_cnt - wr0), 32'(exp_writes));
      check("hold_sp", 32'(sp), 32'(held_sp));
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rsp_done", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int wr0;

    tests         = 0;
    fails         = 0;
    depth         = 0;
    wr_cnt        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = 8'd0;
    bus.req_wdata = 8'd0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'd0;
      model_mem[i] = 8'd0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp", 32'(sp), 32'd255);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load back.
    do_op(2'b01, 8'h10, 8'h5A, 0);
    do_op(2'b00, 8'h10, 8'h00, 0);

    // Push two, pop two.
    do_op(2'b10, 8'h00, 8'h11, 0);
    do_op(2'b10, 8'h00, 8'h22, 0);
    do_op(2'b11, 8'h00, 8'h00, 0);
    do_op(2'b11, 8'h00, 8'h00, 0);

    // Pop on empty, fill the stack, overflow.
    do_op(2'b11, 8'h00, 8'h00, 0);
    for (int i = 0; i < StackCap; i++) do_op(2'b10, 8'($urandom), 8'($urandom), 0);
    do_op(2'b10, 8'h00, 8'hEE, 0);

    // Random mix around the full boundary.
    for (int i = 0; i < 150; i++) begin
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
    end

    // Response backpressure.
    do_op(2'b00, 8'h10, 8'h00, 5);

    // Drain the stack, then random mix around the empty boundary.
    while (depth > 0) do_op(2'b11, 8'h00, 8'h00, 0);
    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
    end
    while (depth > 0) do_op(2'b11, 8'h00, 8'h00, 0);

    // Reset during the ACCESS cycle of a push.
    do_op(2'b01, 8'hFF, 8'hC3, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h77;
    wr0           = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("mid_wr_en", 32'(mem_wr_en), 32'd1);
    check("mid_addr", 32'(mem_addr), 32'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_sp", 32'(sp), 32'd255);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    depth = 0;
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("abort_mem255", 32'(mem[255]), 32'hC3);
    do_op(2'b00, 8'hFF, 8'h00, 0);
    do_op(2'b11, 8'h00, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
